// File: rtl/event_packetizer_pkg.sv
// Shared constants and state type for the TDC event packetizer: message marker,
// part IDs, sequence field width and the FSM encoding.
package EventPacketTypes;

  localparam logic [7:0] MARKER    = 8'hA5;
  localparam logic [3:0] PART_ID_0 = 4'h0;
  localparam logic [3:0] PART_ID_1 = 4'h1;
  localparam int         SEQ_WIDTH = 4;

  // Bits of the event carried by the second message; the rest go in the first.
  localparam int LOW_PART_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LATCH = 3'd2,
    SEND0 = 3'd3,
    SEND1 = 3'd4
  } state_t;

endpackage

// File: rtl/event_packetizer_if.sv
// FIFO-read and USART-transmit signal bundle between the packetizer (master)
// and its FIFO/USART neighbours (slave).
interface event_packetizer_if #(
  parameter int FIFO_DATA_LENGTH = 68,
  parameter int MSG_LENGTH       = 48
);

  logic                        fifo_empty;
  logic                        fifo_read;
  logic [FIFO_DATA_LENGTH-1:0] fifo_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic [MSG_LENGTH-1:0]       tx_data;

  modport master (
    input  fifo_empty, fifo_data, tx_ready,
    output fifo_read, tx_valid, tx_data
  );

  modport slave (
    output fifo_empty, fifo_data, tx_ready,
    input  fifo_read, tx_valid, tx_data
  );

endinterface

// File: rtl/event_packetizer_crc8.sv
// Combinational CRC-8 (poly 0x07, init 0x00, MSB first) over one event word.
// Only instantiated when EVENT_PACKETIZER_CRC_EN is defined.
module event_crc8 #(
  parameter int DATA_WIDTH = 68
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [7:0]            crc
);

  localparam logic [7:0] POLY = 8'h07;

  logic [7:0] crc_acc;
  logic       feedback;

  always_comb begin
    crc_acc  = 8'h00;
    feedback = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      feedback = crc_acc[7] ^ data[i];
      crc_acc  = {crc_acc[6:0], 1'b0} ^ (feedback ? POLY : 8'h00);
    end
  end

  assign crc = crc_acc;

endmodule

// File: rtl/event_packetizer.sv
// Pops one TDC event from the FIFO and sends it as two USART messages.
// Define EVENT_PACKETIZER_CRC_EN to put a CRC-8 of the event in the second message.
module event_packetizer
  import EventPacketTypes::*;
#(
  parameter int FIFO_DATA_LENGTH = 68,
  parameter int MSG_LENGTH       = 48,
  parameter int COUNT_LENGTH     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    busy,
  output logic [COUNT_LENGTH-1:0] events_sent,
  event_packetizer_if.master      bus
);

  state_t                      state_reg;
  state_t                      state_next;
  logic [FIFO_DATA_LENGTH-1:0] event_reg;
  logic [SEQ_WIDTH-1:0]        seq_reg;
  logic [COUNT_LENGTH-1:0]     events_sent_reg;
  logic [7:0]                  marker1;

  logic                        fifo_read_next;
  logic                        tx_valid_next;
  logic [MSG_LENGTH-1:0]       tx_data_next;
  logic [MSG_LENGTH-1:0]       msg0;
  logic [MSG_LENGTH-1:0]       msg1;
  logic                        tx_done;

`ifdef EVENT_PACKETIZER_CRC_EN
  logic [7:0] crc_value;
  logic [7:0] crc_reg;

  // CRC is taken from the FIFO word directly so it is ready in the same LATCH cycle.
  event_crc8 #(
    .DATA_WIDTH(FIFO_DATA_LENGTH)
  ) u_crc (
    .data(bus.fifo_data),
    .crc (crc_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_reg <= 8'h00;
    end else if (state_reg == LATCH) begin
      crc_reg <= crc_value;
    end
  end

  assign marker1 = crc_reg;
`else
  assign marker1 = MARKER;
`endif

  assign msg0 = {MARKER, PART_ID_0, event_reg[FIFO_DATA_LENGTH-1:LOW_PART_WIDTH]};
  assign msg1 = {marker1, PART_ID_1, seq_reg, event_reg[LOW_PART_WIDTH-1:0]};

  assign tx_done = bus.tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      event_reg       <= '0;
      seq_reg         <= '0;
      events_sent_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == LATCH) begin
        event_reg <= bus.fifo_data;
      end
      // An event only counts once its second half has been accepted.
      if (state_reg == SEND1 && tx_done) begin
        seq_reg         <= seq_reg + 1'b1;
        events_sent_reg <= events_sent_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    fifo_read_next = 1'b0;
    tx_valid_next  = 1'b0;
    tx_data_next   = '0;
    case (state_reg)
      IDLE: begin
        if (enable && !bus.fifo_empty) begin
          state_next = POP;
        end
      end
      POP: begin
        fifo_read_next = 1'b1;
        state_next     = LATCH;
      end
      LATCH: begin
        state_next = SEND0;
      end
      SEND0: begin
        tx_valid_next = 1'b1;
        tx_data_next  = msg0;
        if (tx_done) begin
          state_next = SEND1;
        end
      end
      SEND1: begin
        tx_valid_next = 1'b1;
        tx_data_next  = msg1;
        if (tx_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.fifo_read = fifo_read_next;
  assign bus.tx_valid  = tx_valid_next;
  assign bus.tx_data   = tx_data_next;
  assign busy          = (state_reg != IDLE);
  assign events_sent   = events_sent_reg;

endmodule

// File: tb/tb_event_packetizer.sv
// Scoreboard bench for event_packetizer: a FIFO model feeds directed event words,
// expected messages are queued at stimulus time and checked by a forked monitor.
module tb_event_packetizer;

  localparam int FW = 68;
  localparam int MW = 48;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          busy;
  logic [CW-1:0] events_sent;

  event_packetizer_if #(.FIFO_DATA_LENGTH(FW), .MSG_LENGTH(MW)) bus ();

  event_packetizer #(
    .FIFO_DATA_LENGTH(FW),
    .MSG_LENGTH      (MW),
    .COUNT_LENGTH    (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .busy       (busy),
    .events_sent(events_sent),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: word appears on fifo_data the cycle after fifo_read
  logic [FW-1:0] fifo_mem [0:63];
  int push_cnt = 0;
  int pop_cnt  = 0;

  assign bus.fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (bus.fifo_read && pop_cnt < push_cnt) begin
      bus.fifo_data <= fifo_mem[pop_cnt[5:0]];
      pop_cnt       <= pop_cnt + 1;
    end
  end

  logic [MW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef EVENT_PACKETIZER_CRC_EN
  function automatic logic [7:0] crc_model(input logic [FW-1:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = FW - 1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  task automatic push_word(input logic [FW-1:0] w);
    fifo_mem[push_cnt[5:0]] = w;
    push_cnt++;
  endtask

  task automatic push_event(input logic [FW-1:0] w, input logic [MW-1:0] m0,
                            input logic [MW-1:0] m1, input bit apply_crc);
    logic [MW-1:0] m1_exp;
    m1_exp = m1;
`ifdef EVENT_PACKETIZER_CRC_EN
    if (apply_crc) m1_exp[47:40] = crc_model(w);
`else
    if (apply_crc) m1_exp[47:40] = 8'hA5;
`endif
    push_word(w);
    exp_q.push_back(m0);
    exp_q.push_back(m1_exp);
    $display("event %0h queued: msg0=%0h msg1=%0h", w, m0, m1_exp);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!bus.tx_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_tx_valid", bus.tx_valid, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_busy", busy, 0);
    check("wait_idle_drained", exp_q.size(), 0);
  endtask

  task automatic monitor();
    bit            stall_prev;
    logic [MW-1:0] held;
    logic [MW-1:0] expd;
    stall_prev = 0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 0;
      end else begin
        if (bus.fifo_read) check("read_when_empty", bus.fifo_empty, 0);
        if (stall_prev) begin
          check("hold_tx_valid", bus.tx_valid, 1);
          check("hold_tx_data", bus.tx_data, held);
        end
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_tx", bus.tx_data, '1);
          end else begin
            expd = exp_q.pop_front();
            check("tx_data", bus.tx_data, expd);
            $display("tx transfer: data=%0h expected=%0h", bus.tx_data, expd);
          end
        end
        stall_prev = bus.tx_valid && !bus.tx_ready;
        held       = bus.tx_data;
      end
    end
  endtask

  initial begin
    int            lat;
    int            pops;
    logic [FW-1:0] w;
    logic [MW-1:0] m0;
    logic [MW-1:0] m1;

    fork
      monitor();
    join_none

    reset        = 1'b1;
    enable       = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_fifo_read", bus.fifo_read, 0);
    check("rst_busy", busy, 0);
    check("rst_events_sent", events_sent, 0);
    reset = 1'b0;
    tick();

    // Reset in SEND1: first half goes out, second half and the count are discarded
    enable = 1'b1;
    push_word(68'h5_5555_AAAA_1234_5678);
    exp_q.push_back(48'hA505_5555_AAAA);
    wait_valid(10);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check("send1_valid", bus.tx_valid, 1);
    pops   = pop_cnt;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    check("midrst_tx_valid", bus.tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_events_sent", events_sent, 0);
    repeat (4) tick();
    check("midrst_no_pop", pop_cnt, pops);
    check("midrst_drained", exp_q.size(), 0);

    // Basic event with tx_ready high, latency from non-empty to tx_valid
    bus.tx_ready = 1'b1;
    push_event(68'hF_0123_4567_89AB_CDEF, 48'hA50F_0123_4567, 48'hA510_89AB_CDEF, 1);
    lat = 0;
    while (!bus.tx_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", lat, 3);
    wait_idle(20);
    check("events_after_1", events_sent, 1);

    // Stall for 5 cycles in SEND0
    bus.tx_ready = 1'b0;
    pops = pop_cnt;
    push_event(68'h1_2345_6789_0ABC_DEF0, 48'hA501_2345_6789, 48'hA511_0ABC_DEF0, 1);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bus.tx_valid, 1);
      check("stall_data", bus.tx_data, 48'hA501_2345_6789);
      tick();
    end
    bus.tx_ready = 1'b1;
    wait_idle(20);
    check("stall_one_pop", pop_cnt - pops, 1);
    check("events_after_2", events_sent, 2);

    // enable low with data waiting, then enable dropping during SEND0
    enable       = 1'b0;
    bus.tx_ready = 1'b0;
    pops         = pop_cnt;
    push_event(68'hA_BCDE_F012_3456_789A, 48'hA50A_BCDE_F012, 48'hA512_3456_789A, 1);
    repeat (8) tick();
    check("disabled_no_pop", pop_cnt, pops);
    check("disabled_busy", busy, 0);
    enable = 1'b1;
    wait_valid(10);
    enable = 1'b0;
    repeat (2) tick();
    bus.tx_ready = 1'b1;
    wait_idle(20);
    check("enable_drop_events", events_sent, 3);
    check("enable_drop_pops", pop_cnt - pops, 1);

    // 17 back-to-back events from a fresh reset: seq runs 0..15,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_events_sent", events_sent, 0);
    pops = pop_cnt;
    for (int i = 0; i < 17; i++) begin
      w  = {4'h0, 32'h1000_0000 + 32'(i), 32'hC0DE_0000 + 32'(i)};
      m0 = {8'hA5, 4'h0, w[67:32]};
      m1 = {8'hA5, 4'h1, 4'(i % 16), w[31:0]};
      push_event(w, m0, m1, 1);
    end
    enable = 1'b1;
    wait_idle(300);
    check("b2b_events_sent", events_sent, 17);
    check("b2b_pops", pop_cnt - pops, 17);
    repeat (5) tick();
    check("b2b_no_extra_pop", pop_cnt - pops, 17);

`ifdef EVENT_PACKETIZER_CRC_EN
    push_event(68'h0, 48'hA500_0000_0000, 48'h0011_0000_0000, 0);
    push_event(68'h1, 48'hA500_0000_0000, 48'h0712_0000_0001, 0);
    wait_idle(40);
    check("crc_events_sent", events_sent, 19);
`endif

    enable = 1'b0;
    repeat (3) tick();
    check("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
